// File: rtl/expr_mem_responder.sv
// expr_mem_responder: 8x32 operand/result store behind a req/ack handshake; ports clk, rst, en, req, rw, address, in -> out, ack, busy
module expr_mem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              ack,
  output logic              busy
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic ack_q, ack_d;
  logic busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic accept;
  logic rd_done;
  assign accept = state_q == IDLE && en && req;
  assign rd_done = state_q == RD_WAIT && cnt_q == '0;
  assign out = out_q;
  assign ack = ack_q;
  assign busy = busy_q;
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q == IDLE    ? (accept ? (rw ? WR : RD_WAIT) : IDLE)
            : state_q == WR      ? RESP
            : state_q == RD_WAIT ? (rd_done ? RESP : RD_WAIT)
            : IDLE;
  end
  always_comb begin
    addr_d = accept ? address : addr_q;
    data_d = accept ? in : data_q;
    cnt_d = accept ? 4'(RD_LAT - 1) : (state_q == RD_WAIT && !rd_done) ? cnt_q - 4'd1 : cnt_q;
    out_d = rd_done ? mem_q[addr_q] : out_q;
    ack_d = state_q == WR || rd_done;
    busy_d = accept ? 1'b1 : state_q == RESP ? 1'b0 : busy_q;
    mem_d = mem_q;
    if (state_q == WR) mem_d[addr_q] = data_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      out_q <= '0;
      ack_q <= 1'b0;
      busy_q <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      out_q <= out_d;
      ack_q <= ack_d;
      busy_q <= busy_d;
      mem_q <= mem_d;
    end
endmodule

// File: tb/tb_expr_mem_responder.sv
// tb_expr_mem_responder: randomized scoreboard bench for expr_mem_responder
module tb_expr_mem_responder;
  localparam int RD_LAT = 2;
  typedef struct {int cyc; logic w; logic [31:0] data;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic req = 1'b0;
  logic rw = 1'b0;
  logic [2:0] address = '0;
  logic [31:0] in = '0;
  logic [31:0] out;
  logic ack;
  logic busy;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int bf = 1;
  int bu = 0;
  logic [31:0] mem_m [8];
  logic [31:0] out_m = '0;
  exp_t sb [$];
  expr_mem_responder #(.DATA_W(32), .ADDR_W(3), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .rw(rw),
    .address(address), .in(in), .out(out), .ack(ack), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en = $urandom_range(0, 1);
      req = en ? 1'b0 : 1'(($urandom_range(0, 1)));
      rw = $urandom_range(0, 1);
      address = 3'($urandom_range(0, 7));
      in = $urandom;
    end
  endtask
  task automatic txn(input logic w, input logic [2:0] a, input logic [31:0] d, input bit hold);
    int lat;
    @(negedge clk);
    en = 1'b1;
    req = 1'b1;
    rw = w;
    address = a;
    in = d;
    lat = w ? 1 : RD_LAT;
    bf = cyc + 1;
    bu = cyc + 1 + lat;
    if (w) mem_m[a] = d;
    sb.push_back('{cyc + 1 + lat, w, mem_m[a]});
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      en = hold ? 1'b1 : 1'(($urandom_range(0, 1)));
      req = hold ? 1'b1 : 1'(($urandom_range(0, 1)));
      rw = $urandom_range(0, 1);
      address = 3'($urandom_range(0, 7));
      in = $urandom;
    end
  endtask
  initial begin : monitor
    bit due;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        due = sb.size() != 0 && sb[0].cyc == cyc;
        if (ack || (sb.size() != 0 && sb[0].cyc <= cyc)) begin
          chk("ack_timing", 32'(ack), 32'(due));
          if (sb.size() != 0) begin
            e = sb.pop_front();
            if (ack && !e.w) out_m = e.data;
          end
        end
        chk("busy", 32'(busy), 32'(cyc >= bf && cyc <= bu));
        chk("out", out, out_m);
      end
    end
  end
  initial begin
    for (int i = 0; i < 8; i++) mem_m[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    for (int a = 0; a < 8; a++) txn(1'b0, 3'(a), '0, 1'b0);
    txn(1'b1, 3'd0, 32'h7, 1'b0);
    txn(1'b1, 3'd1, 32'h6, 1'b0);
    txn(1'b0, 3'd0, '0, 1'b0);
    txn(1'b0, 3'd1, '0, 1'b0);
    txn(1'b1, 3'd2, 32'h2A, 1'b0);
    idle(2);
    txn(1'b0, 3'd2, '0, 1'b0);
    txn(1'b0, 3'd0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en = 1'b0;
      req = 1'b1;
    end
    for (int a = 0; a < 8; a++) txn(1'b1, 3'(a), 32'(a * 32'h11), 1'b1);
    for (int a = 0; a < 8; a++) txn(1'b0, 3'(a), '0, 1'b1);
    idle(3);
    @(negedge clk);
    en = 1'b1;
    req = 1'b1;
    rw = 1'b1;
    address = 3'd5;
    in = 32'hDEAD_BEEF;
    bf = cyc + 1;
    bu = cyc + 1;
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) mem_m[i] = '0;
    out_m = '0;
    sb.delete();
    rst = 1'b0;
    idle(2);
    txn(1'b0, 3'd5, '0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      txn(1'(($urandom_range(0, 1))), 3'($urandom_range(0, 7)), $urandom, 1'(($urandom_range(0, 1))));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(10);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/expr_mem_responder.md
Name: expr_mem_responder

Overview:
- Memory-side responder for the 8-word x 32-bit operand/result store used by the expression datapath.
- Services one request at a time from a sequencer or initiator. The initiator drives en, rw, address and in, and asserts req.
- The responder accepts the request, performs the write or the fixed-latency read, and returns a one-cycle ack with out valid on read.
- It replaces free-running clk toggling with an explicit request/acknowledge handshake.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 3, address width; depth = 2**ADDR_W words (8).
- RD_LAT, 2, read latency in cycles from accept edge to ack edge; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- en  input  1  port enable; req is ignored while en=0.
- req  input  1  request strobe; sampled only in IDLE.
- rw  input  1  1 = write, 0 = read; latched at accept.
- address  input  ADDR_W  word address; latched at accept.
- in  input  DATA_W  write data; latched at accept.
- out  output  DATA_W  read data; updated only on read completion.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high from accept until the transaction retires.

Behaviour:
- Reset (rst=1 at a rising edge), reset wins over every other input:
  - out=0, ack=0, busy=0, state=IDLE, latency counter=0.
  - All memory words cleared to 0.
- States: IDLE, WR, RD_WAIT, RESP.
- IDLE:
  - At an edge with en=1 and req=1: latch rw, address and in; busy<=1.
  - Next state is WR if rw=1; otherwise RD_WAIT with cnt<=RD_LAT-1.
  - With en=0 or req=0: remain in IDLE; all outputs hold.
- WR:
  - Next edge: mem[addr_q]<=data_q, ack<=1, go to RESP.
  - Write latency is 1 cycle after accept. out is unchanged by writes.
- RD_WAIT:
  - At each edge with cnt!=0: cnt<=cnt-1.
  - At the edge with cnt==0: out<=mem[addr_q], ack<=1, go to RESP.
  - ack is first visible RD_LAT edges after the accept edge.
- RESP:
  - Next edge: ack<=0, busy<=0, go to IDLE.
  - ack is exactly one cycle wide.
- Throughput: at most one transaction per (latency + 2) cycles.
  - The earliest new accept is at the edge after RESP exits.
- req, en, rw, address or in changing while busy=1 have no effect. Latched values are used and no request is queued.
- req held high continuously: a new transaction is accepted on each IDLE edge, i.e. back-to-back with one IDLE cycle between.
- Read-after-write to the same address returns the newly written data, because the write commits before the next accept is possible.
- out holds the last read value indefinitely, including across writes and idle periods.
- Reset mid-transaction: a pending write is discarded (memory cleared anyway), any pending ack is cancelled, and busy drops.
- Addresses span the full 2**ADDR_W range; there is no out-of-range case.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset then idle: assert rst 2 cycles, hold req=0 for 5 cycles -> out=0, ack=0, busy=0 throughout; a read of each of addresses 0..7 afterwards returns 0.
- Write/read pair (RD_LAT=2): write 0x0000_0007 to addr 0 and 0x0000_0006 to addr 1, then read both.
  - Each write: ack one cycle after accept.
  - Each read: ack 2 edges after accept with out=0x7 then out=0x6.
  - busy high for exactly 3 cycles on each read.
- Result write-back: write 0x0000_002A to addr 2, then read addr 2 -> out=0x0000_002A; addr 0 still reads 0x7.
- Gating and ignored inputs:
  - req=1 with en=0 -> no ack, busy stays 0.
  - During a read in progress, toggle address, rw and in -> out equals data at the originally latched address and memory is unchanged.
- Back-to-back: hold req=1, en=1, rw=1 and sweep address 0..7 with in=address*0x11 -> eight acks each separated by the fixed period; a subsequent sweep of reads returns 0x00, 0x11, ..., 0x77.
- Reset mid-operation: accept a write of 0xDEAD_BEEF to addr 5 and assert rst on the next edge -> no ack, busy=0, and addr 5 reads 0.
